// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a circular FIFO of {instr, pc}
// pairs with a one-cycle fill latency and a synchronous flush for redirects.
module fetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = 3,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic full, empty, enq, deq;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == CNT_W'(0));

  // Full blocks enqueue even when decode drains, keeping in_ready off the out_ready path
  assign in_ready    = ~full;
  assign out_valid   = ~empty;
  assign enq         = in_valid & in_ready;
  assign deq         = out_valid & out_ready;
  assign count       = cnt_q;
  assign almost_full = (cnt_q >= CNT_W'(AFULL_THRESH));

  assign out_instr = empty ? NOP_INSTR : instr_mem[rd_ptr_q];
  assign out_pc    = empty ? 32'd0     : pc_mem[rd_ptr_q];

  // Next-state pointers and occupancy; flush overrides any handshake
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq && !deq)      cnt_d = cnt_q + CNT_W'(1);
      else if (deq && !enq) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, drain, wrap, empty bypass, flush, async reset.
module tb_fetch_queue;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;
  logic        almost_full;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] vec_instr [4];
  logic [31:0] vec_pc    [4];

  fetch_queue dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_ready  (out_ready),
    .flush      (flush),
    .count      (count),
    .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_instr[0] = 32'h0010_0093; vec_pc[0] = 32'h0;
    vec_instr[1] = 32'h0020_0113; vec_pc[1] = 32'h4;
    vec_instr[2] = 32'h0020_81B3; vec_pc[2] = 32'h8;
    vec_instr[3] = 32'h0030_2023; vec_pc[3] = 32'hC;

    reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_count",   32'(count), 32'd0);
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_instr",   out_instr, 32'h0000_0013);
    chk("rst_pc",      out_pc, 32'd0);
    chk("rst_inready", 32'(in_ready), 32'd1);
    chk("rst_afull",   32'(almost_full), 32'd0);
    reset_n = 1'b1;

    // 1: fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = vec_instr[i]; in_pc = vec_pc[i];
      tick();
      chk($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
      chk($sformatf("fill_afull%0d", i), 32'(almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("fill_inrdy%0d", i), 32'(in_ready), (i + 1 < 4) ? 32'd1 : 32'd0);
    end
    in_instr = 32'hDEAD_BEEF; in_pc = 32'hFFFF_FFF0;
    tick();
    chk("full_reject_count", 32'(count), 32'd4);
    chk("full_reject_head",  out_instr, vec_instr[0]);
    in_valid = 1'b0;

    // 2: drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_instr%0d", i), out_instr, vec_instr[i]);
      chk($sformatf("drain_pc%0d", i), out_pc, vec_pc[i]);
      tick();
    end
    out_ready = 1'b0;
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_instr", out_instr, 32'h0000_0013);
    chk("empty_pc",    out_pc, 32'd0);
    chk("empty_count", 32'(count), 32'd0);

    // 3: steady enq+deq at count=2 across the pointer wrap
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = 32'h1000_0000 + 32'(k); in_pc = 32'h100 + 32'(4 * k);
      tick();
    end
    chk("pre_wrap_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_instr = 32'h1000_0000 + 32'(k + 2); in_pc = 32'h100 + 32'(4 * (k + 2));
      chk($sformatf("wrap_instr%0d", k), out_instr, 32'h1000_0000 + 32'(k));
      chk($sformatf("wrap_pc%0d", k), out_pc, 32'h100 + 32'(4 * k));
      tick();
      chk($sformatf("wrap_count%0d", k), 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    for (int k = 6; k < 8; k++) begin
      chk($sformatf("wrap_tail%0d", k), out_instr, 32'h1000_0000 + 32'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("wrap_empty", 32'(out_valid), 32'd0);

    // 4: enq and out_ready together on an empty queue, no bypass
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h0050_0293; in_pc = 32'h200;
    #1;
    chk("bypass_none", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bypass_valid", 32'(out_valid), 32'd1);
    chk("bypass_instr", out_instr, 32'h0050_0293);
    chk("bypass_count", 32'(count), 32'd1);

    // 5: flush at count=3 overrides simultaneous enq and deq
    in_valid = 1'b1;
    in_instr = 32'h11; in_pc = 32'h300; tick();
    in_instr = 32'h22; in_pc = 32'h304; tick();
    chk("preflush_count", 32'(count), 32'd3);
    flush = 1'b1; out_ready = 1'b1; in_instr = 32'h33; in_pc = 32'h308;
    #1;
    chk("flushcyc_inready", 32'(in_ready), 32'd1);
    chk("flushcyc_valid",   32'(out_valid), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count",   32'(count), 32'd0);
    chk("flush_valid",   32'(out_valid), 32'd0);
    chk("flush_inready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_instr = 32'h00A0_0513; in_pc = 32'h40;
    tick();
    in_valid = 1'b0;
    chk("postflush_instr", out_instr, 32'h00A0_0513);
    chk("postflush_pc",    out_pc, 32'h40);
    chk("postflush_count", 32'(count), 32'd1);

    // 6: asynchronous reset between edges
    in_valid = 1'b1; in_instr = 32'h55; in_pc = 32'h44;
    tick();
    in_valid = 1'b0;
    chk("prerst_count", 32'(count), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_instr", out_instr, 32'h0000_0013);
    tick();
    reset_n = 1'b1;
    in_valid = 1'b1; in_instr = 32'hCAFE_0001; in_pc = 32'h80;
    tick();
    in_valid = 1'b0;
    chk("postrst_instr", out_instr, 32'hCAFE_0001);
    chk("postrst_pc",    out_pc, 32'h80);
    chk("postrst_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
